alu_seq_unit: RTL and testbench

Parametrised, handshaked ALU control-and-execute stage: decodes the ALU operation from the instruction fields and executes it on two XLEN-bit operands. Logic and arithmetic ops complete in one cycle; shifts use an iterative shifter of SHIFT_STEP bits per cycle. Sits between operand fetch and writeback/branch resolution and replaces the purely combinational ALU operation decode. Results are registered and held under valid/ready back-pressure.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_op_decode.sv | 42 ++++
 rtl/alu_seq_unit.sv | 171 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the sequential ALU stage.
//   - 3-bit ALU operation codes (funct3 encoding)
//   - FSM state codes
//   - branch funct3[2:1] group codes
//   - decoded-operation payload struct and shift-op helper
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Branch class from funct3[2:1]
    localparam logic [1:0] BR_EQ_NE   = 2'b00;
    localparam logic [1:0] BR_RSVD    = 2'b01;
    localparam logic [1:0] BR_LT_GE   = 2'b10;
    localparam logic [1:0] BR_LTU_GEU = 2'b11;

    typedef struct packed {
        logic [2:0] opr;
        logic       sub;
    } alu_dec_t;

    function automatic logic is_shift_op(input logic [2:0] opr);
        return (opr == ALU_SLL) || (opr == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU operation decode from instruction fields.
// Ports:
//   alu_control  in   R / computational-I instruction (op = funct3)
//   ir_type      in   0 = R-type, 1 = I-type
//   branch_en    in   branch instruction
//   is_uncond    in   unconditional jump
//   funct7       in   instruction bit 30
//   funct3       in   instruction funct3
//   dec_c        out  decoded {opr, sub} (combinational)
module alu_op_decode
    import alu_pkg::*;
(
    input  logic       alu_control,
    input  logic       ir_type,
    input  logic       branch_en,
    input  logic       is_uncond,
    input  logic       funct7,
    input  logic [2:0] funct3,
    output alu_dec_t   dec_c
);

    // Compute ops take priority over branch decode; everything else is a plain ADD.
    always_comb begin
        dec_c.opr = ALU_ADD;
        dec_c.sub = 1'b0;
        if (alu_control) begin
            dec_c.opr = funct3;
            // Immediate ADD has no SUB form; bit 30 of ADDI is immediate data
            if (((funct3 == ALU_ADD) && !ir_type) || (funct3 == ALU_SR)) begin
                dec_c.sub = funct7;
            end
        end else if (branch_en && !is_uncond) begin
            case (funct3[2:1])
                BR_EQ_NE:   dec_c.sub = 1'b1;
                BR_LT_GE:   dec_c.opr = ALU_SLT;
                BR_LTU_GEU: dec_c.opr = ALU_SLTU;
                default:    dec_c.opr = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU execute stage with an iterative shifter.
// Single-cycle logic/arithmetic ops; shifts advance SHIFT_STEP bits per cycle.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     operation handshake
//   alu_control, ir_type, branch_en, is_uncond, funct7, funct3  instruction fields
//   opa, opb                operands (shift amount = opb[SHW-1:0])
//   out_valid / out_ready   result handshake
//   result, zero            registered result and result==0 flag
//   alu_opr, sub_or_sra     decoded op of the held result
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            alu_control,
    input  logic            ir_type,
    input  logic            branch_en,
    input  logic            is_uncond,
    input  logic            funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [2:0]      alu_opr,
    output logic            sub_or_sra
);

    localparam int unsigned SHW    = $clog2(XLEN);
    localparam int unsigned STEP_W = SHW + 1;

    logic [0:0]      state_q,     state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            zero_q,      zero_d;
    logic [2:0]      opr_q,       opr_d;
    logic            sub_q,       sub_d;
    logic [SHW-1:0]  rem_q,       rem_d;
    logic [XLEN-1:0] shv_q,       shv_d;

    alu_dec_t        dec_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] alu_c;
    logic [SHW-1:0]  step_c;
    logic [XLEN-1:0] shifted_c;
    logic            accept_c;

    alu_op_decode u_dec (
        .alu_control (alu_control),
        .ir_type     (ir_type),
        .branch_en   (branch_en),
        .is_uncond   (is_uncond),
        .funct7      (funct7),
        .funct3      (funct3),
        .dec_c       (dec_c)
    );

    assign shamt_c  = opb[SHW-1:0];
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // Single-cycle result; a shift only reaches here with amount 0, so it passes opa through.
    always_comb begin
        alu_c = opa;
        case (dec_c.opr)
            ALU_ADD:  alu_c = dec_c.sub ? (opa - opb) : (opa + opb);
            ALU_SLT:  alu_c = XLEN'($signed(opa) < $signed(opb));
            ALU_SLTU: alu_c = XLEN'(opa < opb);
            ALU_XOR:  alu_c = opa ^ opb;
            ALU_OR:   alu_c = opa | opb;
            ALU_AND:  alu_c = opa & opb;
            default:  alu_c = opa;
        endcase
    end

    // One shifter iteration: min(SHIFT_STEP, remaining) bits in the latched direction.
    always_comb begin
        step_c = rem_q;
        if ({1'b0, rem_q} > STEP_W'(SHIFT_STEP)) begin
            step_c = SHW'(SHIFT_STEP);
        end
        shifted_c = shv_q >> step_c;
        if (opr_q == ALU_SLL) begin
            shifted_c = shv_q << step_c;
        end else if (sub_q) begin
            shifted_c = XLEN'($signed(shv_q) >>> step_c);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        opr_d       = opr_q;
        sub_d       = sub_q;
        rem_d       = rem_q;
        shv_d       = shv_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    opr_d = dec_c.opr;
                    sub_d = dec_c.sub;
                    if (is_shift_op(dec_c.opr) && (shamt_c != '0)) begin
                        shv_d   = opa;
                        rem_d   = shamt_c;
                        state_d = SHIFT;
                    end else begin
                        result_d    = alu_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shv_d = shifted_c;
                rem_d = rem_q - step_c;
                if (rem_q == step_c) begin
                    result_d    = shifted_c;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    // State register; reset aborts any shift in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            opr_q       <= ALU_ADD;
            sub_q       <= 1'b0;
            rem_q       <= '0;
            shv_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            opr_q       <= opr_d;
            sub_q       <= sub_d;
            rem_q       <= rem_d;
            shv_q       <= shv_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign alu_opr    = opr_q;
    assign sub_or_sra = sub_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit (XLEN=32, SHIFT_STEP=4).
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        alu_control;
    logic        ir_type;
    logic        branch_en;
    logic        is_uncond;
    logic        funct7;
    logic [2:0]  funct3;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  alu_opr;
    logic        sub_or_sra;

    int checks = 0;
    int errors = 0;

    alu_seq_unit #(.XLEN(32), .SHIFT_STEP(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .ir_type     (ir_type),
        .branch_en   (branch_en),
        .is_uncond   (is_uncond),
        .funct7      (funct7),
        .funct3      (funct3),
        .opa         (opa),
        .opb         (opb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .alu_opr     (alu_opr),
        .sub_or_sra  (sub_or_sra)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic ac, input logic it, input logic be, input logic un,
                          input logic f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        alu_control = ac; ir_type = it; branch_en = be; is_uncond = un;
        funct7 = f7; funct3 = f3; opa = a; opb = b;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic z,
                           input logic [2:0] op, input logic sb);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, result, res);
        chk({tag, "_zero"}, 32'(zero), 32'(z));
        chk({tag, "_opr"}, 32'(alu_opr), 32'(op));
        chk({tag, "_sub"}, 32'(sub_or_sra), 32'(sb));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_opr", 32'(alu_opr), 32'd0);
        chk("rst_sub", 32'(sub_or_sra), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // R-type SUB 5-7
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'd5, 32'd7);
        in_valid = 1'b1;
        step();
        chk_out("sub", 32'hFFFF_FFFE, 1'b0, 3'b000, 1'b1);

        // ADDI with bit 30 set stays an add; back-to-back acceptance
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd3, 32'd4);
        step();
        chk_out("addi", 32'd7, 1'b0, 3'b000, 1'b0);

        // R-type ops; funct7 only qualifies ADD/SR
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 32'hF0F0_1234, 32'h0FF0_FF00);
        step();
        chk_out("and", 32'h00F0_1200, 1'b0, 3'b111, 1'b0);
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'd1);
        step();
        chk_out("slt", 32'd1, 1'b0, 3'b010, 1'b0);

        // SRA by 31: 8 shift cycles with in_ready low, inputs ignored meanwhile
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 32'h8000_0000, 32'd31);
        step();
        for (int i = 0; i < 8; i++) begin
            set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'($urandom), 32'($urandom));
            chk($sformatf("sra_busy%0d", i), 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk_out("sra31", 32'hFFFF_FFFF, 1'b0, 3'b101, 1'b1);
        chk("sra31_ready", 32'(in_ready), 32'd1);

        // Shift amount 0 (upper opb bits ignored) completes in one cycle
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h1234_5678, 32'h0000_0020);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_out("sll0", 32'h1234_5678, 1'b0, 3'b001, 1'b0);

        // SRL by 4 (opb=0x24): one shift cycle
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'h0000_0024);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("srl4_busy", 32'(out_valid), 32'd0);
        step();
        chk_out("srl4", 32'h0800_0000, 1'b0, 3'b101, 1'b0);

        // Branch decodes, back-to-back
        in_valid = 1'b1;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9);
        step();
        chk_out("beq", 32'd0, 1'b1, 3'b000, 1'b1);
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_out("blt", 32'd1, 1'b0, 3'b010, 1'b0);
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_out("bltu", 32'd0, 1'b1, 3'b011, 1'b0);
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_out("br010_wrap", 32'd0, 1'b1, 3'b000, 1'b0);
        set_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'd10, 32'd20);
        step();
        chk_out("jump", 32'd30, 1'b0, 3'b000, 1'b0);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 32'd40, 32'd2);
        step();
        chk_out("default_add", 32'd42, 1'b0, 3'b000, 1'b0);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: hold XOR result while OR waits
        out_ready = 1'b0;
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0);
        in_valid = 1'b1;
        step();
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_result%0d", i), result, 32'h0000_FF00);
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk_out("bp_or", 32'd3, 1'b0, 3'b110, 1'b0);

        // Reset in 3rd cycle of SLL by 20 aborts it
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd1, 32'd20);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_rst_valid", 32'(out_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("abort_novalid%0d", i), 32'(out_valid), 32'd0);
        end
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd100, 32'd23);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_out("post_abort_add", 32'd123, 1'b0, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
